decoder_scan_driver: RTL
========================

// Module: decoder_scan_driver
// PURPOSE
//   Upstream driver for the 2-to-4 enable decoder. Generates the A1/A0 select code and EN strobe that scan the
//   four decoder outputs round-robin. Per channel: fixed EN-high dwell, then an EN-low blanking gap so the
//   select code never changes while EN=1. Masked channels are skipped; WRAP marks the end of each scan frame.
// PARAMETERS
//   DWELL  4  cycles EN is held high per channel; legal range >=1
//   BLANK  1  cycles EN is held low before each channel's dwell; legal range >=0
//   CNT_W  8  width of the internal dwell/blank counter; must hold max(DWELL,BLANK)
// PORTS
//   CLK    in   1  clock, all logic on rising edge
//   RST    in   1  synchronous, active-high reset
//   RUN    in   1  1 = scan; 0 = stop and force EN low
//   MASK   in   4  channel enable, bit i = decoder output Y[i]
//   A0     out  1  select code LSB to decoder, registered
//   A1     out  1  select code MSB to decoder, registered
//   EN     out  1  decoder enable, registered
//   WRAP   out  1  one-cycle pulse when the scan returns to a lower-or-equal channel (frame end)
// BEHAVIOUR
//   - Reset: A1A0=2'b00, EN=0, WRAP=0, state=IDLE, counter=0. Reset mid-scan drops EN on the same edge.
//   - All outputs registered; no combinational path from any input to any output.
//   - FSM states:
//     - IDLE: EN=0. On an edge with RUN=1 and MASK!=0, load A1A0 = lowest set MASK bit.
//       Go to BLANK (BLANK>=1) or ACTIVE (BLANK=0). If MASK=0, stay in IDLE.
//     - BLANK: EN=0, A1A0 stable, count BLANK cycles, then ACTIVE with EN=1.
//     - ACTIVE: EN=1, A1A0 stable, count DWELL cycles. On the last cycle, pick the next set MASK bit
//       strictly above the current channel, modulo 4.
//     - Then: BLANK>=1 -> enter BLANK with EN=0 and the new A1A0. BLANK=0 -> A1A0 changes with EN held at 1.
//   - WRAP: pulses on the edge that loads a next channel <= the current channel.
//     Single-channel mask -> same channel re-selected, WRAP every dwell.
//   - MASK is sampled only at selection points (IDLE exit, end of ACTIVE). Clearing the current channel's
//     bit mid-dwell does not shorten that dwell.
//   - MASK=0 at the end of ACTIVE -> IDLE, EN=0, A1A0 holds, no WRAP.
//   - RUN=0 sampled in any state -> IDLE on that edge: EN=0, WRAP=0, counter cleared, A1A0 holds.
//     Restart always begins at the lowest enabled channel.
//   - Frame length with all 4 channels enabled = 4*(DWELL+BLANK) cycles.
//   - Counter counts 0..N-1 and never exceeds max(DWELL,BLANK)-1. No other arithmetic.
// STRUCTURE
//   - Shared header scan_defs.vh: FSM state encodings (IDLE=2'd0, BLANK=2'd1, ACTIVE=2'd2) and channel-code
//     constants CH0..CH3. Included by this block and its bench.
//   - One combinational sub-module next_ch_pick.
//     - Inputs: mask[3:0], cur[1:0], first.
//     - Outputs: nxt[1:0], wrapped, none.
//     - first=1 returns the lowest set bit; otherwise returns the next set bit after cur, cyclic.
//   - Top level holds the FSM, counter and output registers.
// TESTING
//   1. RST=1 for 3 cycles, RUN=1, MASK=4'hF -> during reset A1A0=00, EN=0, WRAP=0.
//      After release (DWELL=4, BLANK=1) the EN pattern is 0,1111,0,1111... with A1A0 = 0,1,2,3,0.
//      WRAP fires exactly on the 3->0 load; frame = 20 cycles.
//   2. MASK=4'b1010 -> only A1A0 = 01 and 11 are driven with EN=1. Channels 0 and 2 never see EN=1.
//      WRAP on the 3->1 load.
//   3. MASK=4'b0100 -> A1A0 = 10 every dwell, EN low 1 cycle between dwells, WRAP every 5 cycles.
//   4. RUN 1->0 on the 2nd dwell cycle of channel 1 -> EN=0 at the next edge, A1A0 holds 01.
//      RUN back to 1 -> restart at channel 0 after a full BLANK.
//   5. MASK cleared to 0 mid-dwell -> dwell completes its 4 cycles, then IDLE with EN=0 and no WRAP.
//      Assert RST mid-dwell -> EN=0 and A1A0=00 on the reset edge.
//   6. Rebuild with BLANK=0, DWELL=2 -> EN stays 1 continuously, A1A0 changes every 2 cycles.
//      Checker: A1A0 never changes while EN=1 whenever BLANK>=1.

Source files
------------

// File: rtl/decoder_scan_driver_pkg.sv
// Shared definitions for the decoder scan driver: FSM state codes and
// decoder channel (A1A0) codes.
package decoder_scan_driver_pkg;

    // FSM state encodings (kept numerically identical to the legacy header)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BLANK  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Channel codes presented on A1A0
    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

endpackage

// File: rtl/decoder_scan_driver_next_ch_pick.sv
// Combinational channel selector: lowest set mask bit on a fresh start,
// otherwise the next set bit after the current channel, cyclic.
module next_ch_pick
    import decoder_scan_driver_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    input  logic       first,
    output logic [1:0] nxt,
    output logic       wrapped,
    output logic       none
);

    logic       found;
    logic [1:0] idx;

    // Priority search; on a cyclic search the current channel is tried last,
    // so a single-channel mask re-selects itself and reports a wrap.
    always_comb begin
        nxt     = cur;
        found   = 1'b0;
        idx     = CH0;
        none    = (mask == '0);
        if (first) begin
            for (int unsigned i = 0; i < 4; i++) begin
                idx = i[1:0];
                if (!found && mask[idx]) begin
                    nxt   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 1; i <= 4; i++) begin
                idx = cur + i[1:0];
                if (!found && mask[idx]) begin
                    nxt   = idx;
                    found = 1'b1;
                end
            end
        end
        wrapped = !first && found && (nxt <= cur);
    end

endmodule

// File: rtl/decoder_scan_driver.sv
// Round-robin scan driver for a 2-to-4 enable decoder. Each enabled channel
// gets an EN-low blanking gap followed by an EN-high dwell; the select code
// only changes while EN is low (unless BLANK is zero).
module decoder_scan_driver
    import decoder_scan_driver_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1,
    parameter int unsigned CNT_W = 8
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic [3:0] MASK,
    output logic       A0,
    output logic       A1,
    output logic       EN,
    output logic       WRAP
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       ch_q,    ch_d;
    logic             en_q,    en_d;
    logic             wrap_q,  wrap_d;

    logic [1:0]       pick_nxt;
    logic             pick_wrapped;
    logic             pick_none;

    next_ch_pick u_pick (
        .mask    (MASK),
        .cur     (ch_q),
        .first   (state_q == ST_IDLE),
        .nxt     (pick_nxt),
        .wrapped (pick_wrapped),
        .none    (pick_none)
    );

    // Next-state logic for FSM, dwell/blank counter and output registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        en_d    = en_q;
        wrap_d  = 1'b0;
        if (!RUN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    en_d = 1'b0;
                    if (!pick_none) begin
                        ch_d  = pick_nxt;
                        cnt_d = '0;
                        if (BLANK == 0) begin
                            state_d = ST_ACTIVE;
                            en_d    = 1'b1;
                        end else begin
                            state_d = ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    en_d = 1'b0;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_ACTIVE;
                        en_d    = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    en_d = 1'b1;
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (pick_none) begin
                            state_d = ST_IDLE;
                            en_d    = 1'b0;
                        end else begin
                            ch_d   = pick_nxt;
                            wrap_d = pick_wrapped;
                            if (BLANK != 0) begin
                                state_d = ST_BLANK;
                                en_d    = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_q    <= CH0;
            en_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
        end
    end

    assign A0   = ch_q[0];
    assign A1   = ch_q[1];
    assign EN   = en_q;
    assign WRAP = wrap_q;

endmodule
